// File: rtl/keysw_io_dev_pkg.sv
// Shared definitions for the KEY/SW memory-mapped input device.
// Holds register addresses, CTRL bit positions and the status-register update rule.
package keysw_io_dev_pkg;

    localparam logic [31:0] ADDR_KDATA = 32'hFFFF_F080;
    localparam logic [31:0] ADDR_KCTRL = 32'hFFFF_F084;
    localparam logic [31:0] ADDR_SDATA = 32'hFFFF_F090;
    localparam logic [31:0] ADDR_SCTRL = 32'hFFFF_F094;

    localparam int CTRL_READY = 0;
    localparam int CTRL_OVR   = 2;
    localparam int CTRL_IE    = 4;
    localparam int CTRL_BITS  = 5;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_KDATA,
        REG_KCTRL,
        REG_SDATA,
        REG_SCTRL
    } regSel_t;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic ready;
    } ctrl_t;

    function automatic logic [CTRL_BITS-1:0] ctrlWord(input ctrl_t c);
        logic [CTRL_BITS-1:0] w;
        w = '0;
        w[CTRL_READY] = c.ready;
        w[CTRL_OVR]   = c.ovr;
        w[CTRL_IE]    = c.ie;
        return w;
    endfunction

    // A data update that coincides with a data read counts as consumed, so it never flags overrun.
    function automatic ctrl_t ctrlNext(input ctrl_t cur, input logic update, input logic dataRead,
                                       input logic ctrlWrite, input logic wrOvr, input logic wrIe);
        ctrl_t nxt;
        nxt = cur;
        if (ctrlWrite) begin
            if (!wrOvr) nxt.ovr = 1'b0;
            nxt.ie = wrIe;
        end
        if (update) begin
            nxt.ready = 1'b1;
            if (cur.ready && !dataRead) nxt.ovr = 1'b1;
        end else if (dataRead) begin
            nxt.ready = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/keysw_io_dev_debounce.sv
// Two-flop synchroniser followed by a stability filter; DEBOUNCE<=1 bypasses the filter.
// o_changed is high in the cycle before o_value takes a new value.
module keysw_io_dev_debounce #(
    parameter int WIDTH    = 10,
    parameter int DEBOUNCE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_value,
    output logic             o_changed
);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (DEBOUNCE > 1) begin : g_filter
            localparam int CW = $clog2(DEBOUNCE);
            localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE - 1);

            logic [WIDTH-1:0] r_cand;
            logic [CW-1:0]    r_cnt;
            logic [CW-1:0]    w_nextCnt;
            logic             w_load;

            // Counter saturates at CMAX; acceptance happens on the edge it gets there.
            always_comb begin
                w_nextCnt = r_cnt;
                if (r_sync2 != r_cand) begin
                    w_nextCnt = '0;
                end else if (r_cnt != CMAX) begin
                    w_nextCnt = r_cnt + CW'(1);
                end
            end

            assign w_load = (r_sync2 == r_cand) && (w_nextCnt == CMAX) && (r_cand != r_value);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cand  <= '0;
                    r_cnt   <= '0;
                    r_value <= '0;
                end else begin
                    r_cand <= r_sync2;
                    r_cnt  <= w_nextCnt;
                    if (w_load) r_value <= r_cand;
                end
            end

            assign o_changed = w_load;
        end else begin : g_bypass
            logic w_load;

            assign w_load = (r_sync2 != r_value);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_value <= '0;
                end else if (w_load) begin
                    r_value <= r_sync2;
                end
            end

            assign o_changed = w_load;
        end
    endgenerate

    assign o_value = r_value;

endmodule

// File: rtl/keysw_io_dev.sv
// Memory-mapped KEY/SW input device: synchronised data registers, Ready/Overrun/IE status
// per device, address decode, combinational read mux and a registered interrupt request.
module keysw_io_dev
    import keysw_io_dev_pkg::*;
#(
    parameter int               DBITS     = 32,
    parameter int               KEYBITS   = 4,
    parameter int               SWBITS    = 10,
    parameter int               DEBOUNCE  = 100000,
    parameter logic [DBITS-1:0] ADDRKDATA = DBITS'(ADDR_KDATA),
    parameter logic [DBITS-1:0] ADDRKCTRL = DBITS'(ADDR_KCTRL),
    parameter logic [DBITS-1:0] ADDRSDATA = DBITS'(ADDR_SDATA),
    parameter logic [DBITS-1:0] ADDRSCTRL = DBITS'(ADDR_SCTRL)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DBITS-1:0]   addr,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [DBITS-1:0]   wdata,
    input  logic [KEYBITS-1:0] KEY,
    input  logic [SWBITS-1:0]  SW,
    output logic [DBITS-1:0]   rdata,
    output logic               sel,
    output logic               irq
);

    logic [KEYBITS-1:0] w_kdata;
    logic               w_kChanged;
    logic [SWBITS-1:0]  w_sdata;
    logic               w_sChanged;
    regSel_t            w_regSel;
    logic               w_kRead;
    logic               w_sRead;
    logic               w_kCtrlWr;
    logic               w_sCtrlWr;
    logic               w_unusedWdata;

    ctrl_t r_kCtrl;
    ctrl_t r_sCtrl;
    logic  r_irq;

    // KEY is inverted ahead of the synchroniser so the all-zero reset state means "nothing pressed".
    keysw_io_dev_debounce #(
        .WIDTH    (KEYBITS),
        .DEBOUNCE (1)
    ) u_keyIn (
        .clk       (clk),
        .reset     (reset),
        .i_raw     (~KEY),
        .o_value   (w_kdata),
        .o_changed (w_kChanged)
    );

    keysw_io_dev_debounce #(
        .WIDTH    (SWBITS),
        .DEBOUNCE (DEBOUNCE)
    ) u_swIn (
        .clk       (clk),
        .reset     (reset),
        .i_raw     (SW),
        .o_value   (w_sdata),
        .o_changed (w_sChanged)
    );

    always_comb begin
        w_regSel = REG_NONE;
        if (addr == ADDRKDATA)      w_regSel = REG_KDATA;
        else if (addr == ADDRKCTRL) w_regSel = REG_KCTRL;
        else if (addr == ADDRSDATA) w_regSel = REG_SDATA;
        else if (addr == ADDRSCTRL) w_regSel = REG_SCTRL;
    end

    assign sel       = (w_regSel != REG_NONE);
    assign w_kRead   = rd_en && (w_regSel == REG_KDATA);
    assign w_sRead   = rd_en && (w_regSel == REG_SDATA);
    assign w_kCtrlWr = wr_en && (w_regSel == REG_KCTRL);
    assign w_sCtrlWr = wr_en && (w_regSel == REG_SCTRL);

    // Only the Overrun and IE bits of a store matter.
    assign w_unusedWdata = ^wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kCtrl <= '0;
            r_sCtrl <= '0;
            r_irq   <= 1'b0;
        end else begin
            r_kCtrl <= ctrlNext(r_kCtrl, w_kChanged, w_kRead, w_kCtrlWr,
                                wdata[CTRL_OVR], wdata[CTRL_IE]);
            r_sCtrl <= ctrlNext(r_sCtrl, w_sChanged, w_sRead, w_sCtrlWr,
                                wdata[CTRL_OVR], wdata[CTRL_IE]);
            r_irq   <= (r_kCtrl.ready && r_kCtrl.ie) || (r_sCtrl.ready && r_sCtrl.ie);
        end
    end

    assign irq = r_irq;

    always_comb begin
        rdata = '0;
        case (w_regSel)
            REG_KDATA: rdata[KEYBITS-1:0]   = w_kdata;
            REG_KCTRL: rdata[CTRL_BITS-1:0] = ctrlWord(r_kCtrl);
            REG_SDATA: rdata[SWBITS-1:0]    = w_sdata;
            REG_SCTRL: rdata[CTRL_BITS-1:0] = ctrlWord(r_sCtrl);
            default:   rdata = '0;
        endcase
    end

endmodule
